// File: rtl/seg_scan_decoder_if.sv
// Bus between a multiplexed 7-segment display and its read-back decoder.
// The display side drives segments and digit select, and the decoder returns the captured digits.
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 6
);
    logic [7:0]              seg_data;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [4*NUM_DIGITS-1:0] bcd_all;
    logic [NUM_DIGITS-1:0]   dot_all;
    logic [NUM_DIGITS-1:0]   pat_err;
    logic                    frame_done;
    logic                    sel_err;

    modport master (
        output seg_data, digit_sel,
        input  bcd_all, dot_all, pat_err, frame_done, sel_err
    );

    modport slave (
        input  seg_data, digit_sel,
        output bcd_all, dot_all, pat_err, frame_done, sel_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit BCD values from a scanned 7-segment bus.
// A digit is committed once its segment/select pattern has been stable for STABLE_CNT samples.
module seg_scan_decoder #(
    parameter int NUM_DIGITS = 6,
    parameter int STABLE_CNT = 4
) (
    input logic              clk,
    input logic              rst,
    seg_scan_decoder_if.slave bus
);

    localparam logic [3:0] CNT_MAX  = 4'(STABLE_CNT);
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);

    logic [NUM_DIGITS-1:0]   prev_sel;
    logic [7:0]              prev_seg;
    logic [3:0]              cnt;
    logic [NUM_DIGITS-1:0]   captured;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   dot_q;
    logic [NUM_DIGITS-1:0]   perr_q;
    logic                    frame_done_q;
    logic                    sel_err_q;

    logic [NUM_DIGITS-1:0] sel;
    logic [7:0]            seg;
    logic                  sel_none;
    logic                  one_hot;
    logic                  same;
    logic                  commit;
    logic                  frame_hit;
    logic [3:0]            cnt_next;
    logic [4:0]            decoded;
    logic [NUM_DIGITS-1:0] captured_set;

    // Returns {illegal, bcd}; blank decodes to 4'hA and counts as legal.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b0000000: r = 5'h0A;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    // NOTE: every signal gets a value on every path here, so no latches are inferred.
    always_comb begin
        sel          = bus.digit_sel;
        seg          = bus.seg_data;
        sel_none     = (sel == '0);
        one_hot      = !sel_none && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        same         = (sel == prev_sel) && (seg == prev_seg);
        commit       = one_hot && same && (cnt == CNT_LAST);
        captured_set = captured | sel;
        frame_hit    = commit && (captured_set == '1);
        decoded      = decode(seg[7:1]);
        if (!one_hot)
            cnt_next = 4'd0;
        else if (!same)
            cnt_next = 4'd1;
        else if (cnt == CNT_MAX)
            cnt_next = cnt;
        else
            cnt_next = cnt + 4'd1;
    end

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sel     <= '0;
            prev_seg     <= '0;
            cnt          <= '0;
            captured     <= '0;
            bcd_q        <= '0;
            dot_q        <= '0;
            perr_q       <= '0;
            frame_done_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            prev_sel     <= sel;
            prev_seg     <= seg;
            cnt          <= cnt_next;
            frame_done_q <= frame_hit;
            if (!sel_none && !one_hot)
                sel_err_q <= 1'b1;
            if (commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        bcd_q[4*i +: 4] <= decoded[3:0];
                        dot_q[i]        <= seg[0];
                        perr_q[i]       <= decoded[4];
                    end
                end
                // The completing digit is not carried into the next frame.
                captured <= frame_hit ? '0 : captured_set;
            end
        end
    end

    assign bus.bcd_all    = bcd_q;
    assign bus.dot_all    = dot_q;
    assign bus.pat_err    = perr_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sel_err    = sel_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (NUM_DIGITS=6, STABLE_CNT=4).
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
module tb_seg_scan_decoder;

    localparam logic [7:0] S0 = 8'hFC, S1 = 8'h60, S2 = 8'hDA, S3 = 8'hF2, S4 = 8'h66;
    localparam logic [7:0] S5 = 8'hB6, S7 = 8'hE0, S8 = 8'hFE, S9 = 8'hF6;
    localparam logic [7:0] SBAD = 8'h81, SBLANK = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fd_cnt = 0;
    int   fd0;
    logic [7:0] enc_tab [6];
    logic [7:0] r_seg;
    logic [5:0] r_sel;

    seg_scan_decoder_if #(.NUM_DIGITS(6)) bus ();

    seg_scan_decoder #(.NUM_DIGITS(6), .STABLE_CNT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.frame_done === 1'b1) fd_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] seg, input logic [5:0] sel, input int n);
        for (int k = 0; k < n; k++) begin
            bus.seg_data  = seg;
            bus.digit_sel = sel;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(8'h00, 6'b0, 2);
        rst = 1'b0;
    endtask

    initial begin
        enc_tab = '{S1, S2, S3, S4, S5, S9};
        bus.seg_data  = 8'h00;
        bus.digit_sel = 6'b0;

        // Reset state
        do_reset();
        chk("rst_bcd", 32'(bus.bcd_all), 32'h0);
        chk("rst_dot", 32'(bus.dot_all), 32'h0);
        chk("rst_perr", 32'(bus.pat_err), 32'h0);
        chk("rst_fd", 32'(bus.frame_done), 32'h0);
        chk("rst_selerr", 32'(bus.sel_err), 32'h0);

        // Mid-run reset with random inputs
        drive(S8, 6'b000010, 4);
        chk("pre_rst_commit", 32'(bus.bcd_all), 32'h000080);
        drive(S2, 6'b000001, 2);
        r_seg = 8'($urandom);
        r_sel = 6'($urandom);
        rst = 1'b1;
        drive(r_seg, r_sel, 1);
        rst = 1'b0;
        chk("midrst_bcd", 32'(bus.bcd_all), 32'h0);
        chk("midrst_dot", 32'(bus.dot_all), 32'h0);
        chk("midrst_selerr", 32'(bus.sel_err), 32'h0);
        drive(S7, 6'b000001, 3);
        chk("post_rst_3cyc", 32'(bus.bcd_all), 32'h0);
        drive(S7, 6'b000001, 1);
        chk("post_rst_4cyc", 32'(bus.bcd_all), 32'h000007);

        // Encode loop over all six digits
        do_reset();
        fd0 = fd_cnt;
        for (int i = 0; i < 6; i++) begin
            r_seg = enc_tab[i] | ((i == 2) ? 8'h01 : 8'h00);
            r_sel = 6'b1 << i;
            drive(r_seg, r_sel, 4);
            chk($sformatf("enc_fd_d%0d", i), 32'(bus.frame_done), (i == 5) ? 32'h1 : 32'h0);
            if (i == 5) chk("enc_bcd_at_fd", 32'(bus.bcd_all), 32'h954321);
            drive(r_seg, r_sel, 1);
        end
        chk("enc_fd_cleared", 32'(bus.frame_done), 32'h0);
        chk("enc_fd_count", 32'(fd_cnt - fd0), 32'h1);
        chk("enc_bcd", 32'(bus.bcd_all), 32'h954321);
        chk("enc_dot", 32'(bus.dot_all), 32'h04);
        chk("enc_perr", 32'(bus.pat_err), 32'h0);

        // Glitch restarts the window
        do_reset();
        drive(S7, 6'b000001, 3);
        chk("glitch_a", 32'(bus.bcd_all), 32'h0);
        drive(S1, 6'b000001, 1);
        chk("glitch_b", 32'(bus.bcd_all), 32'h0);
        drive(S7, 6'b000001, 3);
        chk("glitch_c", 32'(bus.bcd_all), 32'h0);
        drive(S7, 6'b000001, 1);
        chk("glitch_commit", 32'(bus.bcd_all), 32'h000007);

        // Illegal pattern, then blank
        drive(SBAD, 6'b001000, 4);
        chk("illegal_bcd", 32'(bus.bcd_all), 32'h00F007);
        chk("illegal_perr", 32'(bus.pat_err), 32'h08);
        chk("illegal_dot", 32'(bus.dot_all), 32'h08);
        drive(SBLANK, 6'b001000, 4);
        chk("blank_bcd", 32'(bus.bcd_all), 32'h00A007);
        chk("blank_perr", 32'(bus.pat_err), 32'h0);
        chk("blank_dot", 32'(bus.dot_all), 32'h0);

        // Multi-hot and all-zero select
        fd0 = fd_cnt;
        drive(S8, 6'b000011, 10);
        chk("multihot_bcd", 32'(bus.bcd_all), 32'h00A007);
        chk("multihot_selerr", 32'(bus.sel_err), 32'h1);
        drive(S8, 6'b000000, 10);
        chk("zero_sel_bcd", 32'(bus.bcd_all), 32'h00A007);
        chk("zero_sel_selerr", 32'(bus.sel_err), 32'h1);
        chk("selfault_fd", 32'(fd_cnt - fd0), 32'h0);
        do_reset();
        chk("selerr_cleared", 32'(bus.sel_err), 32'h0);

        // Saturation: long hold commits once
        fd0 = fd_cnt;
        drive(S8, 6'b000010, 4);
        chk("sat_commit", 32'(bus.bcd_all), 32'h000080);
        drive(S8, 6'b000010, 16);
        chk("sat_hold", 32'(bus.bcd_all), 32'h000080);
        chk("sat_no_fd", 32'(fd_cnt - fd0), 32'h0);

        // Two complete frames
        for (int i = 0; i < 6; i++) begin
            drive(S3, 6'b1 << i, 4);
            if (i == 4) chk("f1_no_early_fd", 32'(fd_cnt - fd0), 32'h0);
        end
        chk("f1_fd", 32'(bus.frame_done), 32'h1);
        chk("f1_bcd", 32'(bus.bcd_all), 32'h333333);
        for (int i = 0; i < 6; i++) begin
            drive(S8, 6'b1 << i, 4);
            if (i == 4) begin
                chk("f2_no_early_fd", 32'(fd_cnt - fd0), 32'h1);
                chk("f2_fd_low", 32'(bus.frame_done), 32'h0);
            end
        end
        chk("f2_fd", 32'(bus.frame_done), 32'h1);
        chk("f2_bcd", 32'(bus.bcd_all), 32'h888888);
        drive(S8, 6'b100000, 1);
        chk("f2_fd_count", 32'(fd_cnt - fd0), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Decodes the multiplexed 7-segment display bus back into per-digit BCD values, making it the inverse of the display's BCD-to-segment encoding. It watches the segment lines and one-hot digit select driven to the clock display and qualifies each pattern by requiring a stable sample window. It latches one decoded value per digit and pulses when a full display frame has been captured. It sits beside the display driver for loopback self-test and read-back of the displayed time.

## Interface
- NUM_DIGITS, 6, number of multiplexed digits (1..8)
- STABLE_CNT, 4, consecutive identical samples required to commit a digit (2..15)

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- SEG_DATA  in  8  segment bus: bit7=a, bit6=b … bit1=g, bit0=DOT; 1 = lit
- DIGIT_SEL  in  NUM_DIGITS  digit enable, one-hot, active high
- BCD_ALL  out  4*NUM_DIGITS  decoded digits; digit i in bits [4i+3:4i]
- DOT_ALL  out  NUM_DIGITS  decoded DOT per digit
- PAT_ERR  out  NUM_DIGITS  per-digit flag: last committed pattern was illegal
- FRAME_DONE  out  1  one-cycle pulse when every digit has committed since the last pulse or reset
- SEL_ERR  out  1  sticky flag: multi-hot DIGIT_SEL seen

## Operation
- Legal 7-bit patterns (a..g) and their decodes:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
  - 0000000 (blank)→4'hA, which is legal
- Any other pattern is illegal: it commits BCD 4'hF, sets PAT_ERR[i], and still captures DOT.
- Sampling: SEG_DATA and DIGIT_SEL are sampled every cycle into registers prev_sel and prev_seg.
- Stability counter cnt (4 bits):
  - Sample equals previous sample and DIGIT_SEL is one-hot: cnt increments, saturating at STABLE_CNT.
  - Sample differs (either SEL or SEG): cnt=1 when the new SEL is one-hot, else 0.
  - DIGIT_SEL all-zero: cnt=0 and no commit (blanking interval).
  - DIGIT_SEL multi-hot: cnt=0, no commit, and SEL_ERR set until RST.
- Commit happens exactly once per stable run, on the edge where cnt goes from STABLE_CNT-1 to STABLE_CNT. A commit:
  - writes BCD_ALL[i], DOT_ALL[i] and PAT_ERR[i] for the selected digit i;
  - sets captured[i].
  - A legal commit clears PAT_ERR[i].
  - Holding the same input longer causes no re-commit.
- Frame tracking:
  - When a commit makes captured all-ones, FRAME_DONE=1 for one cycle and captured clears to 0.
  - Re-committing an already-captured digit only overwrites its data.
- RST, including mid-run: BCD_ALL=0, DOT_ALL=0, PAT_ERR=0, FRAME_DONE=0, SEL_ERR=0, captured=0, cnt=0, prev_sel=0, prev_seg=0. The first cycle after reset counts as a change.

## Timing
- Input stable from cycle t through t+STABLE_CNT-1 (STABLE_CNT samples): digit outputs update on the edge ending cycle t+STABLE_CNT-1 and are visible in cycle t+STABLE_CNT.
- FRAME_DONE is registered in the same edge as the completing commit, so it is visible in the same cycle as that digit's new data.
- A glitch of one differing sample restarts the window; the run that follows needs a full STABLE_CNT samples.
- Committed outputs hold indefinitely between commits.
- Simultaneous commit and frame completion: the data is written and FRAME_DONE pulses in the same cycle. captured resets to 0 and does not keep the completing bit.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert RST mid-window with random inputs → all outputs 0 the next cycle; a 3-cycle stable window after release gives no commit (STABLE_CNT=4).
- Encode loop: for NUM_DIGITS=6, scan digits 0..5 with patterns for 1,2,3,4,5,9, DOT set on digit 2, each held 5 cycles → BCD_ALL=24'h954321, DOT_ALL=6'b000100, exactly one FRAME_DONE pulse in the cycle digit 5 commits.
- Glitch: digit 0 shows "7" for 3 cycles, "1" for 1 cycle, then "7" for 4 cycles → only "7" commits, on the 4th cycle of the final run; "1" never appears.
- Illegal and blank: digit 3 shows 1000000 → BCD 4'hF, PAT_ERR[3]=1. Then 0000000 → BCD 4'hA, PAT_ERR[3]=0.
- Selection faults: DIGIT_SEL=6'b000011 for 10 cycles → no commit, SEL_ERR=1 and held until RST. DIGIT_SEL=0 for 10 cycles → no commit, SEL_ERR unchanged.
- Saturation and re-capture: hold digit 1 at "8" for 20 cycles → exactly one commit and no FRAME_DONE. Complete the frame twice → two FRAME_DONE pulses, and captured restarts from empty after each.
